// File: rtl/microstepper_chopper.sv
// Step/direction position counter plus one peak-current chopper FSM per H-bridge channel.
// A shared latched fault parks every channel with both low sides on until reset.
//   state | meaning
//   IDLE  | bridge disabled, both low sides on
//   DEAD  | all gates off before conduction or after a polarity change
//   BLANK | driving, comparator ignored while the current spike settles
//   ON    | driving until the peak comparator trips
//   FAST  | reversed drive, fast decay
//   SLOW  | both low sides on, slow decay
//   FAULT | latched shutdown, both low sides on
module microstepper_chopper #(
  parameter int NCH = 2,
  parameter int TW  = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             step,
  input  logic             dir,
  input  logic [NCH-1:0]   pol,
  input  logic [NCH-1:0]   cmp,
  input  logic [TW-1:0]    cfg_blank,
  input  logic [TW-1:0]    cfg_fast,
  input  logic [TW-1:0]    cfg_slow,
  input  logic [TW-1:0]    cfg_dead,
  input  logic [TW-1:0]    cfg_min_on,
  input  logic             cfg_inv_hi,
  input  logic             cfg_inv_lo,
  output logic [2*NCH-1:0] hi,
  output logic [2*NCH-1:0] lo,
  output logic [NCH-1:0]   off_active,
  output logic [7:0]       phase_ct,
  output logic             faultn
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEAD, ST_BLANK, ST_ON, ST_FAST, ST_SLOW, ST_FAULT
  } state_t;

  typedef struct packed {
    state_t        st;
    logic [TW-1:0] cnt;
    logic          clr_ton;
  } entry_t;

  localparam logic [TW-1:0] ONE = TW'(1);

  // Resolve the state actually entered: timed states with a zero count fall through
  // to their successor in the same transition; every chain ends in ON.
  function automatic entry_t enter(input state_t s, input logic [TW-1:0] c_dead,
                                   input logic [TW-1:0] c_blank, input logic [TW-1:0] c_fast,
                                   input logic [TW-1:0] c_slow);
    entry_t e;
    e.st      = s;
    e.cnt     = '0;
    e.clr_ton = 1'b0;
    if (e.st == ST_FAST) begin
      if (c_fast != '0) e.cnt = c_fast;
      else e.st = ST_SLOW;
    end
    if (e.st == ST_SLOW) begin
      if (c_slow != '0) e.cnt = c_slow;
      else e.st = ST_BLANK;
    end
    if (e.st == ST_DEAD) begin
      if (c_dead != '0) e.cnt = c_dead;
      else e.st = ST_BLANK;
    end
    if (e.st == ST_BLANK) begin
      e.clr_ton = 1'b1;
      if (c_blank != '0) e.cnt = c_blank;
      else e.st = ST_ON;
    end
    return e;
  endfunction

  entry_t ent_dead, ent_blank, ent_fast, ent_slow;
  assign ent_dead  = enter(ST_DEAD,  cfg_dead, cfg_blank, cfg_fast, cfg_slow);
  assign ent_blank = enter(ST_BLANK, cfg_dead, cfg_blank, cfg_fast, cfg_slow);
  assign ent_fast  = enter(ST_FAST,  cfg_dead, cfg_blank, cfg_fast, cfg_slow);
  assign ent_slow  = enter(ST_SLOW,  cfg_dead, cfg_blank, cfg_fast, cfg_slow);

  logic step_s1, step_s2, step_s3, dir_s1, dir_s2;
  logic [NCH-1:0] fault_ch;
  logic           fault_req;

  assign fault_req = |fault_ch;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      step_s3  <= 1'b0;
      dir_s1   <= 1'b0;
      dir_s2   <= 1'b0;
      phase_ct <= 8'd0;
      faultn   <= 1'b1;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
      dir_s1  <= dir;
      dir_s2  <= dir_s1;
      if (step_s2 && !step_s3) phase_ct <= dir_s2 ? phase_ct + 8'd1 : phase_ct - 8'd1;
      if (fault_req) faultn <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q;
    entry_t        ent;
    logic [TW-1:0] cnt_q, ton_q, ton_d;
    logic          pol_q, pol_chg, expired, regulating, rev;
    logic [1:0]    want_hi, want_lo, hi_q, lo_q;
    logic          off_q;

    assign pol_chg     = pol[i] ^ pol_q;
    assign expired     = (cnt_q == ONE);
    assign regulating  = state_q inside {ST_BLANK, ST_ON, ST_FAST, ST_SLOW};
    assign fault_ch[i] = (state_q == ST_ON) && cmp[i] && (ton_q < cfg_min_on);

    always_comb begin
      ent.st      = state_q;
      ent.cnt     = (cnt_q == '0) ? '0 : cnt_q - ONE;
      ent.clr_ton = 1'b0;
      if (fault_req || !faultn) begin
        ent.st  = ST_FAULT;
        ent.cnt = '0;
      end else if (state_q == ST_FAULT) begin
        ent.cnt = '0;
      end else if (!enable) begin
        ent.st  = ST_IDLE;
        ent.cnt = '0;
      end else if (pol_chg && regulating) begin
        ent = ent_dead;
      end else begin
        case (state_q)
          ST_IDLE:  ent = ent_dead;
          ST_DEAD:  if (expired) ent = ent_blank;
          ST_BLANK: if (expired) ent.st = ST_ON;
          ST_ON:    if (cmp[i]) ent = ent_fast;
          ST_FAST:  if (expired) ent = ent_slow;
          ST_SLOW:  if (expired) ent = ent_blank;
          default:  ;
        endcase
      end
    end

    always_comb begin
      ton_d = ton_q;
      if (ent.clr_ton) ton_d = '0;
      else if ((state_q == ST_BLANK || state_q == ST_ON) && ton_q != '1) ton_d = ton_q + ONE;
    end

    // Bit 0 is half-bridge A; the sourcing half swaps with polarity and in FAST.
    assign rev = pol_q ^ (state_q == ST_FAST);

    always_comb begin
      want_hi = 2'b00;
      want_lo = 2'b11;
      if (state_q inside {ST_BLANK, ST_ON, ST_FAST}) begin
        want_hi = rev ? 2'b10 : 2'b01;
        want_lo = rev ? 2'b01 : 2'b10;
      end else if (state_q == ST_DEAD) begin
        want_lo = 2'b00;
      end
    end

    // A high side may only turn on if its low side was already off last cycle, so
    // direct low-to-high handovers (ON->FAST, SLOW->BLANK) get one cycle of gap.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        ton_q   <= '0;
        pol_q   <= 1'b0;
        hi_q    <= 2'b00;
        lo_q    <= 2'b11;
        off_q   <= 1'b0;
      end else begin
        state_q <= ent.st;
        cnt_q   <= ent.cnt;
        ton_q   <= ton_d;
        pol_q   <= pol[i];
        hi_q    <= want_hi & ~lo_q;
        lo_q    <= want_lo;
        off_q   <= (state_q == ST_FAST) || (state_q == ST_SLOW);
      end
    end

    assign hi[2*i +: 2]  = hi_q ^ {2{cfg_inv_hi}};
    assign lo[2*i +: 2]  = lo_q ^ {2{cfg_inv_lo}};
    assign off_active[i] = off_q;
  end

endmodule

// File: tb/tb_microstepper_chopper.sv
// Directed bench for microstepper_chopper: a cycle model of the chopper flow is compared
// against the DUT every cycle, plus hand-computed checks and gate-safety checks.
module tb_microstepper_chopper;
  localparam int NCH = 2;
  localparam int TW  = 10;
  localparam int P_IDLE = 0, P_DEAD = 1, P_BLANK = 2, P_ON = 3, P_FAST = 4, P_SLOW = 5, P_FAULT = 6;

  logic        clk = 1'b0;
  logic        resetn, enable, step, dir, cfg_inv_hi, cfg_inv_lo;
  logic [1:0]  pol, cmp;
  logic [9:0]  cfg_blank, cfg_fast, cfg_slow, cfg_dead, cfg_min_on;
  logic [3:0]  hi, lo;
  logic [1:0]  off_active;
  logic [7:0]  phase_ct;
  logic        faultn;

  microstepper_chopper #(.NCH(NCH), .TW(TW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .step(step), .dir(dir),
    .pol(pol), .cmp(cmp), .cfg_blank(cfg_blank), .cfg_fast(cfg_fast),
    .cfg_slow(cfg_slow), .cfg_dead(cfg_dead), .cfg_min_on(cfg_min_on),
    .cfg_inv_hi(cfg_inv_hi), .cfg_inv_lo(cfg_inv_lo), .hi(hi), .lo(lo),
    .off_active(off_active), .phase_ct(phase_ct), .faultn(faultn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [3:0] rh, rl;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases with remaining-cycle counts, flow and duration tables.
  int  m_ph[NCH], m_left[NCH], m_ton[NCH];
  bit  m_polq[NCH];
  bit  [3:0] m_hi, m_lo;
  bit  [1:0] m_off;
  bit  m_faultn;
  int  m_phase;
  bit  sh1, sh2, sh3, dh1, dh2;

  function automatic int dur(input int p);
    case (p)
      P_DEAD:  return int'(cfg_dead);
      P_BLANK: return int'(cfg_blank);
      P_FAST:  return int'(cfg_fast);
      P_SLOW:  return int'(cfg_slow);
      default: return 0;
    endcase
  endfunction

  function automatic int flow(input int p);
    case (p)
      P_DEAD:  return P_BLANK;
      P_FAST:  return P_SLOW;
      P_SLOW:  return P_BLANK;
      default: return P_ON;
    endcase
  endfunction

  task automatic enter(input int p, output int ph, output int left, output bit clr);
    clr = 1'b0;
    while (p != P_ON && dur(p) == 0) begin
      if (p == P_BLANK) clr = 1'b1;
      p = flow(p);
    end
    if (p == P_BLANK) clr = 1'b1;
    ph = p;
    left = dur(p);
  endtask

  task automatic model_step();
    int nph[NCH], nleft[NCH], nton[NCH];
    bit clr, fault_any;
    bit [3:0] nhi, nlo;
    bit [1:0] noff;
    if (!resetn) begin
      for (int c = 0; c < NCH; c++) begin
        m_ph[c] = P_IDLE; m_left[c] = 0; m_ton[c] = 0; m_polq[c] = 1'b0;
      end
      m_hi = 4'h0; m_lo = 4'hF; m_off = 2'b00; m_faultn = 1'b1; m_phase = 0;
      sh1 = 0; sh2 = 0; sh3 = 0; dh1 = 0; dh2 = 0;
      return;
    end
    if (sh2 && !sh3) m_phase = dh2 ? (m_phase + 1) % 256 : (m_phase + 255) % 256;
    sh3 = sh2; sh2 = sh1; sh1 = step; dh2 = dh1; dh1 = dir;
    fault_any = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (m_ph[c] == P_ON && cmp[c] && m_ton[c] < int'(cfg_min_on)) fault_any = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      int src;
      bit wh, wl, conducting;
      conducting = (m_ph[c] == P_BLANK || m_ph[c] == P_ON || m_ph[c] == P_FAST);
      src = int'(m_polq[c]) ^ int'(m_ph[c] == P_FAST);
      for (int h = 0; h < 2; h++) begin
        if (conducting) begin wh = (h == src); wl = (h != src); end
        else if (m_ph[c] == P_DEAD) begin wh = 0; wl = 0; end
        else begin wh = 0; wl = 1; end
        nhi[2*c+h] = wh && !m_lo[2*c+h];
        nlo[2*c+h] = wl;
      end
      noff[c] = (m_ph[c] == P_FAST || m_ph[c] == P_SLOW);
      nph[c] = m_ph[c];
      nleft[c] = (m_left[c] > 0) ? m_left[c] - 1 : 0;
      clr = 1'b0;
      if (fault_any || !m_faultn) begin nph[c] = P_FAULT; nleft[c] = 0; end
      else if (m_ph[c] == P_FAULT) nleft[c] = 0;
      else if (!enable) begin nph[c] = P_IDLE; nleft[c] = 0; end
      else if (pol[c] != m_polq[c] && m_ph[c] >= P_BLANK && m_ph[c] <= P_SLOW)
        enter(P_DEAD, nph[c], nleft[c], clr);
      else if (m_ph[c] == P_IDLE) enter(P_DEAD, nph[c], nleft[c], clr);
      else if (m_ph[c] == P_ON) begin
        if (cmp[c]) enter(P_FAST, nph[c], nleft[c], clr);
      end else if (m_left[c] == 1) enter(flow(m_ph[c]), nph[c], nleft[c], clr);
      if (clr) nton[c] = 0;
      else if (m_ph[c] == P_BLANK || m_ph[c] == P_ON) nton[c] = (m_ton[c] < 1023) ? m_ton[c] + 1 : 1023;
      else nton[c] = m_ton[c];
    end
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = nph[c]; m_left[c] = nleft[c]; m_ton[c] = nton[c]; m_polq[c] = pol[c];
    end
    m_hi = nhi; m_lo = nlo; m_off = noff;
    if (fault_any) m_faultn = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin : compare
    logic [3:0] ph_prev, pl_prev, ch, cl;
    ph_prev = 4'h0;
    pl_prev = 4'hF;
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        check("hi", int'(hi), int'(m_hi ^ {4{cfg_inv_hi}}));
        check("lo", int'(lo), int'(m_lo ^ {4{cfg_inv_lo}}));
        check("off_active", int'(off_active), int'(m_off));
        check("phase_ct", int'(phase_ct), m_phase);
        check("faultn", int'(faultn), int'(m_faultn));
        ch = hi ^ {4{cfg_inv_hi}};
        cl = lo ^ {4{cfg_inv_lo}};
        check("shoot_through", int'(ch & cl), 0);
        check("hi_after_lo", int'(ch & ~ph_prev & pl_prev), 0);
        ph_prev = ch;
        pl_prev = cl;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    rh = hi ^ {4{cfg_inv_hi}};
    rl = lo ^ {4{cfg_inv_lo}};
  endtask

  task automatic set_cfg(input int d, input int b, input int f, input int s, input int m);
    cfg_dead = 10'(d); cfg_blank = 10'(b); cfg_fast = 10'(f); cfg_slow = 10'(s); cfg_min_on = 10'(m);
  endtask

  task automatic do_reset();
    resetn = 0; enable = 0; step = 0; dir = 0; pol = 2'b00; cmp = 2'b00;
    tick(3);
    check("rst_hi", int'(rh), 0);
    check("rst_lo", int'(rl), 15);
    check("rst_phase", int'(phase_ct), 0);
    check("rst_faultn", int'(faultn), 1);
    check("rst_off", int'(off_active), 0);
    resetn = 1;
    tick(1);
  endtask

  task automatic pulses(input int n, input bit d);
    dir = d;
    repeat (n) begin
      step = 1; tick(2);
      step = 0; tick(2);
    end
  endtask

  task automatic scen_phase();
    set_cfg(2, 4, 3, 5, 0);
    do_reset();
    pulses(5, 1'b1);
    pulses(2, 1'b0);
    tick(4);
    check("phase_5up_2down", int'(phase_ct), 3);
    do_reset();
    pulses(258, 1'b1);
    tick(4);
    check("phase_wrap_258", int'(phase_ct), 2);
  endtask

  task automatic scen_chop();
    int n_dead0, n_dead1, n_off0, n_off1;
    set_cfg(2, 4, 3, 5, 0);
    do_reset();
    enable = 1;
    n_dead0 = 0; n_dead1 = 0;
    repeat (12) begin
      tick(1);
      if (rh[0] == 0 && rl[0] == 0) n_dead0++;
      if (rh[2] == 0 && rl[2] == 0) n_dead1++;
    end
    check("dead_cycles_ch0", n_dead0, 2);
    check("dead_cycles_ch1", n_dead1, 2);
    check("on_drive_hi", int'(rh), 5);
    check("on_drive_lo", int'(rl), 10);
    tick(4);
    cmp = 2'b01;
    tick(1);
    cmp = 2'b00;
    n_off0 = 0; n_off1 = 0;
    repeat (30) begin
      tick(1);
      if (off_active[0]) n_off0++;
      if (off_active[1]) n_off1++;
    end
    check("off_cycles_ch0", n_off0, 8);
    check("off_cycles_ch1", n_off1, 0);
    check("faultn_min_on0", int'(faultn), 1);
    enable = 0;
    tick(2);
    check("disable_hi", int'(rh), 0);
    check("disable_lo", int'(rl), 15);
  endtask

  task automatic scen_fault();
    set_cfg(2, 4, 3, 5, 20);
    do_reset();
    enable = 1;
    tick(12);
    cmp = 2'b01;
    tick(1);
    check("fault_next_cycle", int'(faultn), 0);
    cmp = 2'b00;
    tick(2);
    check("fault_hi", int'(rh), 0);
    check("fault_lo", int'(rl), 15);
    enable = 0; tick(3);
    enable = 1; tick(5);
    check("fault_held", int'(faultn), 0);
    check("fault_held_hi", int'(rh), 0);
    check("fault_held_lo", int'(rl), 15);
    do_reset();
    enable = 1;
    tick(12);
    cmp = 2'b01;
    resetn = 0;
    tick(1);
    check("reset_beats_fault", int'(faultn), 1);
    do_reset();
  endtask

  task automatic scen_pol();
    int n_dead, n_ch1;
    set_cfg(3, 4, 3, 5, 0);
    do_reset();
    enable = 1;
    tick(16);
    pol = 2'b01;
    n_dead = 0; n_ch1 = 0;
    repeat (12) begin
      tick(1);
      if (rh[1:0] == 2'b00 && rl[1:0] == 2'b00) n_dead++;
      if (rh[3:2] != 2'b01 || rl[3:2] != 2'b10) n_ch1++;
    end
    check("pol_dead_cycles", n_dead, 3);
    check("pol_ch1_undisturbed", n_ch1, 0);
    check("pol_rev_hi", int'(rh[1:0]), 2);
    check("pol_rev_lo", int'(rl[1:0]), 1);
  endtask

  task automatic scen_loop();
    int n_off;
    set_cfg(2, 4, 0, 0, 4);
    do_reset();
    enable = 1;
    cmp = 2'b11;
    n_off = 0;
    repeat (60) begin
      tick(1);
      if (off_active != 2'b00) n_off++;
    end
    check("loop_no_fault", int'(faultn), 1);
    check("loop_no_off", n_off, 0);
    check("loop_drive_hi", int'(rh), 5);
    set_cfg(2, 4, 0, 0, 5);
    do_reset();
    enable = 1;
    cmp = 2'b11;
    tick(20);
    check("loop_min_on_fault", int'(faultn), 0);
    cmp = 2'b00;
    enable = 0;
  endtask

  initial begin
    resetn = 0; enable = 0; step = 0; dir = 0; pol = 2'b00; cmp = 2'b00;
    cfg_inv_hi = 0; cfg_inv_lo = 0;
    set_cfg(0, 0, 0, 0, 0);
    tick(1);
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_inv_hi = k[0];
      cfg_inv_lo = k[1];
      scen_phase();
      scen_chop();
      scen_fault();
      scen_pol();
      scen_loop();
    end
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microstepper_chopper.md
MICROSTEPPER_CHOPPER -- requirements
Module: microstepper_chopper

Interface
REQ-001 Parameter NCH, default 2, number of H-bridge channels (1..8).
REQ-002 Parameter TW, default 10, width of every timer config input and internal timer counter.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  bridge enable; low forces every channel to IDLE.
REQ-006 step, dir  input  1 each  asynchronous step pulse and direction.
REQ-007 pol  input  NCH  desired current polarity per channel, from the commutation table.
REQ-008 cmp  input  NCH  peak-current comparator per channel, active high.
REQ-009 cfg_blank, cfg_fast, cfg_slow, cfg_dead, cfg_min_on  input  TW each  tick counts shared by all channels.
REQ-010 cfg_inv_hi, cfg_inv_lo  input  1 each  output polarity inversion for high and low sides.
REQ-011 hi, lo  output  2*NCH  gate drives; bits 2i and 2i+1 are half-bridges A and B of channel i.
REQ-012 off_active  output  NCH  channel is in FAST or SLOW.
REQ-013 phase_ct  output  8  microstep position.
REQ-014 faultn  output  1  latched fault, active low.

Function
REQ-015 step and dir pass through a 2-flop synchroniser; a rising edge is a synchronised 0->1 transition.
REQ-016 On a detected rising edge, phase_ct updates on the next edge: +1 if the synchronised dir is 1, else -1, wrapping modulo 256.
REQ-017 Each channel has an independent FSM with states IDLE, DEAD, BLANK, ON, FAST, SLOW, FAULT, a TW-bit down-counter, and a TW-bit saturating on-time counter.
REQ-018 Loading count N>=1 keeps the state for exactly N cycles; a zero count skips the state in the same transition.
REQ-019 IDLE -> DEAD (count cfg_dead) when enable=1 and faultn=1.
REQ-020 DEAD -> BLANK (count cfg_blank); entering BLANK clears the on-time counter.
REQ-021 BLANK -> ON at counter expiry; cmp is ignored during BLANK.
REQ-022 ON has no timeout; cmp=1 -> FAST (count cfg_fast).
REQ-023 FAST -> SLOW (count cfg_slow) at expiry.
REQ-024 SLOW -> BLANK at expiry.
REQ-025 If cfg_fast=cfg_slow=0, ON -> BLANK directly on cmp=1.
REQ-026 The on-time counter increments in BLANK and ON.
REQ-027 cmp=1 in ON with on-time < cfg_min_on is a fault; faultn falls on the next edge and holds low until reset.
REQ-028 faultn=0 forces all channels to FAULT on the same edge; FAULT exits only on reset.
REQ-029 A change of pol[i], detected against a registered copy, in BLANK, ON, FAST or SLOW forces DEAD (count cfg_dead), then normal flow resumes.
REQ-030 enable=0 forces IDLE on the next edge from any state except FAULT.
REQ-031 Raw drive, pol=0, in BLANK or ON: A hi=1 lo=0, B hi=0 lo=1; pol=1 mirrors this.
REQ-032 FAST uses the reversed drive of REQ-031.
REQ-033 SLOW, IDLE and FAULT drive both halves hi=0 lo=1.
REQ-034 DEAD drives both halves hi=0 lo=0.
REQ-035 hi and lo are registered one cycle after state, then XORed with cfg_inv_hi and cfg_inv_lo respectively.
REQ-036 Raw hi=1 with raw lo=1 on the same half-bridge shall never occur.
REQ-037 Raw hi on a half-bridge shall never go 0->1 in the cycle after its raw lo was 1; polarity reversal always passes through DEAD.
REQ-038 off_active is registered and aligned with hi and lo.

Reset
REQ-039 While resetn=0: phase_ct=0, faultn=1, all FSMs IDLE, counters 0, raw hi=0, raw lo=1 (outputs apply inversion), off_active=0, synchronisers cleared.
REQ-040 Reset takes priority over every event in the same cycle, including a fault or step edge.

Verification
REQ-041 Five step pulses with dir=1, then two with dir=0 from reset -> phase_ct=3; 258 pulses with dir=1 -> phase_ct=2.
REQ-042 NCH=2, cfg_dead=2, cfg_blank=4, cfg_fast=3, cfg_slow=5, cfg_min_on=0; enable, cmp pulse after 10 ON cycles -> channel state sequence DEAD2, BLANK4, ON, FAST3, SLOW5, BLANK; off_active high 8 cycles.
REQ-043 cfg_min_on=20, cmp=1 at on-time 10 -> faultn=0 next cycle, all hi=0, lo=1; remains until resetn=0.
REQ-044 pol[0] toggles mid-ON with cfg_dead=3 -> channel 0 hi=lo=0 for 3 cycles, then reversed drive; channel 1 unaffected.
REQ-045 cfg_fast=cfg_slow=0, cmp held 1 -> ON->BLANK loop, each BLANK ignoring cmp.
REQ-046 Across all scenarios a bench assertion checks REQ-036 and REQ-037 every cycle, for cfg_inv_hi/cfg_inv_lo in all four combinations.
